// File: rtl/cond_logic_unit_pkg.sv
// Shared encodings for the execute-stage condition logic:
// condition codes, NZCV bit positions and ALU op codes.
package cond_logic_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/cond_logic_unit_check.sv
// Pure combinational Cond x NZCV evaluator.
// Encoding 4'b1111 behaves as AL.
module cond_check
  import cond_logic_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       condex
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    condex = 1'b1;
    unique case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_HS: condex = c;
      COND_LO: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      default: condex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic_unit.sv
// NZCV flag register, condition evaluation and
// write-strobe gating just downstream of the ALU.
module cond_logic_unit
  import cond_logic_unit_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS      = 4'b0000,
  parameter bit         INVERT_SUB_CARRY = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       ALUSub,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  input  logic       Flush,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic we;
  logic cin;

  cond_check u_check (
    .cond   (Cond),
    .nzcv   (Flags),
    .condex (CondEx)
  );

  // ALU reports borrow on SUB; architectural C is NOT borrow
  assign cin = ALUFlags[FLAG_C] ^ (INVERT_SUB_CARRY & ALUSub);
  assign we  = CondEx & ~Stall & ~Flush & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Flags <= RESET_FLAGS;
    end else begin
      if (FlagW[1] & we) begin
        Flags[FLAG_N] <= ALUFlags[FLAG_N];
        Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[0] & we) begin
        Flags[FLAG_C] <= cin;
        Flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  assign PCSrc    = PCS & CondEx & ~Flush;
  assign RegWrite = RegW & CondEx & ~NoWrite & ~Flush;
  assign MemWrite = MemW & CondEx & ~Flush;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Directed bench for cond_logic_unit with a reference
// model of the flags and condition table.
module tb_cond_logic_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       ALUSub;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       NoWrite, Stall, Flush;
  logic       CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;

  int n_vec = 0;
  int n_err = 0;
  bit chk   = 1'b0;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  cond_logic_unit #(
    .RESET_FLAGS      (4'b0000),
    .INVERT_SUB_CARRY (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .ALUSub   (ALUSub),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .Flush    (Flush),
    .CondEx   (CondEx),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  // Conditions come in true/false pairs: cond[0] negates the base test.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    base = 1'b0;
    case (cc[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: return 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_flags <= 4'b0000;
    end else if (ref_cond(Cond, m_flags) && !Stall && !Flush) begin
      if (FlagW[1]) m_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) m_flags[1:0] <= {ALUFlags[1] ^ ALUSub, ALUFlags[0]};
    end
  end

  task automatic cmp(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      logic cx;
      cx = ref_cond(Cond, m_flags);
      cmp("flags", Flags, m_flags);
      cmp("condex", {3'b0, CondEx}, {3'b0, cx});
      cmp("pcsrc", {3'b0, PCSrc}, {3'b0, PCS && cx && !Flush});
      cmp("regwrite", {3'b0, RegWrite}, {3'b0, RegW && cx && !NoWrite && !Flush});
      cmp("memwrite", {3'b0, MemWrite}, {3'b0, MemW && cx && !Flush});
    end
  end

  task automatic go(
    input logic       rst,
    input logic [3:0] cc,
    input logic [3:0] alu,
    input logic       sub,
    input logic [1:0] fw,
    input logic       pcs,
    input logic       rw,
    input logic       mw,
    input logic       nw,
    input logic       st,
    input logic       fl
  );
    @(posedge clk);
    #1;
    reset_n  = rst;
    Cond     = cc;
    ALUFlags = alu;
    ALUSub   = sub;
    FlagW    = fw;
    PCS      = pcs;
    RegW     = rw;
    MemW     = mw;
    NoWrite  = nw;
    Stall    = st;
    Flush    = fl;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] v);
    go(1, 4'hE, v, 0, 2'b11, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0; Cond = 0; ALUFlags = 0; ALUSub = 0; FlagW = 0;
    PCS = 1; RegW = 1; MemW = 1; NoWrite = 0; Stall = 0; Flush = 0;

    go(0, 4'h0, 4'hF, 0, 2'b11, 1, 1, 1, 0, 0, 0);
    chk = 1'b1;
    go(0, 4'h0, 4'hF, 0, 2'b11, 1, 1, 1, 0, 0, 0);
    cmp("rst_flags", Flags, 4'b0000);
    cmp("rst_condex", {3'b0, CondEx}, 4'd0);
    cmp("rst_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);

    // CMP equal: raw borrow C=1 becomes architectural C=0
    go(1, 4'hE, 4'b0110, 1, 2'b11, 0, 1, 0, 1, 0, 0);
    cmp("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
    cmp("cmp_condex", {3'b0, CondEx}, 4'd1);
    go(1, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("cmp_flags", Flags, 4'b0100);
    cmp("cmp_eq", {3'b0, CondEx}, 4'd1);
    go(1, 4'h2, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("cmp_hs", {3'b0, CondEx}, 4'd0);

    // partial write of N,Z only
    load(4'b1111);
    go(1, 4'hE, 4'b0000, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    cmp("part_pre", Flags, 4'b1111);
    go(1, 4'hE, 4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("part_post", Flags, 4'b0011);

    // failed condition blocks both strobes and flag write
    load(4'b0000);
    go(1, 4'h0, 4'b1111, 0, 2'b11, 1, 1, 1, 0, 0, 0);
    cmp("fail_condex", {3'b0, CondEx}, 4'd0);
    cmp("fail_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);
    go(1, 4'hE, 4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("fail_flags", Flags, 4'b0000);

    // stall holds flags but not strobes; flush kills strobes
    go(1, 4'hE, 4'b1001, 0, 2'b11, 1, 1, 1, 0, 1, 0);
    cmp("stall_regwrite", {3'b0, RegWrite}, 4'd1);
    go(1, 4'hE, 4'b1001, 0, 2'b11, 1, 1, 1, 0, 0, 1);
    cmp("stall_flags", Flags, 4'b0000);
    cmp("flush_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);
    go(1, 4'hE, 4'b1001, 0, 2'b11, 1, 1, 1, 0, 1, 1);
    cmp("flush_flags", Flags, 4'b0000);
    cmp("fl_st_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);
    go(1, 4'hE, 4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("fl_st_flags", Flags, 4'b0000);

    // reset wins over an in-flight flag write
    load(4'b1010);
    go(0, 4'hE, 4'b1111, 0, 2'b11, 0, 0, 0, 0, 0, 0);
    cmp("mid_pre", Flags, 4'b1010);
    go(1, 4'hE, 4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cmp("mid_rst", Flags, 4'b0000);

    // full NZCV x Cond sweep
    for (int f = 0; f < 16; f++) begin
      load(4'(f));
      for (int c = 0; c < 16; c++) begin
        go(1, 4'(c), 4'hF, 0, 2'b00, 1, 1, 1, 0, 0, 0);
        if (f == 4'b1001 && c == 4'hC) cmp("gt_nv", {3'b0, CondEx}, 4'd1);
        if (f == 4'b0100 && c == 4'hD) cmp("le_z", {3'b0, CondEx}, 4'd1);
        if (f == 4'b1000 && c == 4'hB) cmp("lt_n", {3'b0, CondEx}, 4'd1);
        if (f == 4'b0110 && c == 4'h8) cmp("hi_cz", {3'b0, CondEx}, 4'd0);
        if (f == 4'b0000 && c == 4'hF) cmp("nv_al", {3'b0, CondEx}, 4'd1);
      end
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
